// File: rtl/lda_coef_loader.sv
// Framed, checksummed coefficient loader for the LDA classifier.
// Words fill a shadow bank; a good checksum commits it atomically to the active bank.
module lda_coef_loader #(
   parameter int unsigned     DIMS    = 6,
   parameter int unsigned     CLASSES = 3,
   parameter int unsigned     WIDTH   = 16,
   parameter logic [WIDTH-1:0] HEADER = 16'hA5C3
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             abort_i,
   output logic [WIDTH-1:0] w_o [DIMS][CLASSES],
   output logic [WIDTH-1:0] c_o [CLASSES],
   output logic             coef_valid_o,
   output logic             frame_ok_o,
   output logic             frame_err_o
);

   localparam int unsigned RW = (DIMS > 1) ? $clog2(DIMS) : 1;
   localparam int unsigned CW = (CLASSES > 1) ? $clog2(CLASSES) : 1;

   typedef enum logic [2:0] {StIdle, StLoadW, StLoadC, StCheck, StCommit} state_t;

   state_t           r_state;
   logic [RW-1:0]    r_row;
   logic [CW-1:0]    r_col;
   logic [CW-1:0]    r_cidx;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_sw [DIMS][CLASSES];
   logic [WIDTH-1:0] r_sc [CLASSES];
   logic [WIDTH-1:0] r_w  [DIMS][CLASSES];
   logic [WIDTH-1:0] r_c  [CLASSES];
   logic             r_cv;
   logic             r_ok;
   logic             r_err;
   logic             w_acc;

   // Ready is combinational on reset so nothing is accepted while rstn_i is low.
   assign in_ready_o   = rstn_i && (r_state != StCommit);
   assign w_acc        = in_valid_i && in_ready_o;
   assign w_o          = r_w;
   assign c_o          = r_c;
   assign coef_valid_o = r_cv;
   assign frame_ok_o   = r_ok;
   assign frame_err_o  = r_err;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= StIdle;
         r_row   <= '0;
         r_col   <= '0;
         r_cidx  <= '0;
         r_sum   <= '0;
         r_cv    <= 1'b0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
         for (int d = 0; d < DIMS; d++) begin
            for (int k = 0; k < CLASSES; k++) begin
               r_sw[d][k] <= '0;
               r_w[d][k]  <= '0;
            end
         end
         for (int k = 0; k < CLASSES; k++) begin
            r_sc[k] <= '0;
            r_c[k]  <= '0;
         end
      end else begin
         r_ok  <= 1'b0;
         r_err <= 1'b0;
         if (abort_i) begin
            // Abort wins over any accept and suppresses a pending commit.
            r_state <= StIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_cidx  <= '0;
            r_sum   <= '0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (w_acc && (in_data_i == HEADER)) begin
                     r_state <= StLoadW;
                     r_row   <= '0;
                     r_col   <= '0;
                     r_cidx  <= '0;
                     r_sum   <= '0;
                  end
               end
               StLoadW: begin
                  if (w_acc) begin
                     r_sw[r_row][r_col] <= in_data_i;
                     r_sum              <= r_sum + in_data_i;
                     if (r_col == CW'(CLASSES - 1)) begin
                        r_col <= '0;
                        if (r_row == RW'(DIMS - 1)) begin
                           r_row   <= '0;
                           r_cidx  <= '0;
                           r_state <= StLoadC;
                        end else begin
                           r_row <= r_row + RW'(1);
                        end
                     end else begin
                        r_col <= r_col + CW'(1);
                     end
                  end
               end
               StLoadC: begin
                  if (w_acc) begin
                     r_sc[r_cidx] <= in_data_i;
                     r_sum        <= r_sum + in_data_i;
                     if (r_cidx == CW'(CLASSES - 1)) begin
                        r_cidx  <= '0;
                        r_state <= StCheck;
                     end else begin
                        r_cidx <= r_cidx + CW'(1);
                     end
                  end
               end
               StCheck: begin
                  if (w_acc) begin
                     if (in_data_i == r_sum) begin
                        r_state <= StCommit;
                     end else begin
                        r_state <= StIdle;
                        r_err   <= 1'b1;
                     end
                  end
               end
               StCommit: begin
                  r_w     <= r_sw;
                  r_c     <= r_sc;
                  r_cv    <= 1'b1;
                  r_ok    <= 1'b1;
                  r_state <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lda_coef_loader.sv
// Directed, table-driven bench for lda_coef_loader with a small active-bank model.
module tb_lda_coef_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        abort;
   logic [15:0] w_out [6][3];
   logic [15:0] c_out [3];
   logic        coef_valid;
   logic        frame_ok;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_w [6][3];
   logic [15:0] exp_c [3];
   logic        exp_cv;

   typedef struct {
      logic [15:0] base;
      logic [15:0] step;
      logic [15:0] bad;
      int          gap;
      logic        exp_ok;
   } vec_t;

   vec_t vecs [5];

   lda_coef_loader dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .abort_i     (abort),
      .w_o         (w_out),
      .c_o         (c_out),
      .coef_valid_o(coef_valid),
      .frame_ok_o  (frame_ok),
      .frame_err_o (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bank(input string tag);
      for (int d = 0; d < 6; d++)
         for (int k = 0; k < 3; k++)
            chk($sformatf("%s w[%0d][%0d]", tag, d, k), 32'(w_out[d][k]), 32'(exp_w[d][k]));
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s c[%0d]", tag, k), 32'(c_out[k]), 32'(exp_c[k]));
      chk({tag, " coef_valid"}, 32'(coef_valid), 32'(exp_cv));
   endtask

   task automatic clear_model();
      for (int d = 0; d < 6; d++)
         for (int k = 0; k < 3; k++)
            exp_w[d][k] = 16'h0;
      for (int k = 0; k < 3; k++)
         exp_c[k] = 16'h0;
      exp_cv = 1'b0;
   endtask

   // Present one word and hold it until accepted (bounded wait).
   task automatic send_word(input logic [15:0] d, input int gap);
      int n = 0;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_plan_frame(input logic [15:0] csum);
      send_word(16'hA5C3, 0);
      for (int k = 1; k <= 18; k++) send_word(16'(k), 0);
      send_word(16'd100, 0);
      send_word(16'd200, 0);
      send_word(16'd300, 0);
      send_word(csum, 0);
   endtask

   // Frame of words base + step*k; the checksum is the bench's own sum plus 'bad'.
   task automatic run_frame(input string tag, input vec_t v);
      logic [15:0] fw [21];
      logic [15:0] sum = 16'h0;
      for (int k = 0; k < 21; k++) begin
         fw[k] = v.base + 16'(v.step * 16'(k));
         sum   = sum + fw[k];
      end
      send_word(16'hA5C3, (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0);
      for (int k = 0; k < 21; k++)
         send_word(fw[k], (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0);
      send_word(sum + v.bad, 0);
      chk({tag, " err_pulse"}, 32'(frame_err), 32'(!v.exp_ok));
      chk({tag, " ok_early"}, 32'(frame_ok), 32'd0);
      tick();
      if (v.exp_ok) begin
         for (int k = 0; k < 18; k++) exp_w[k / 3][k % 3] = fw[k];
         for (int k = 0; k < 3; k++) exp_c[k] = fw[18 + k];
         exp_cv = 1'b1;
      end
      chk({tag, " ok_pulse"}, 32'(frame_ok), 32'(v.exp_ok));
      chk({tag, " err_clear"}, 32'(frame_err), 32'd0);
      chk_bank(tag);
   endtask

   initial begin
      vecs[0] = '{base: 16'h0010, step: 16'h0001, bad: 16'h0001, gap: 0, exp_ok: 1'b0};
      vecs[1] = '{base: 16'h0020, step: 16'h0003, bad: 16'h0000, gap: 0, exp_ok: 1'b1};
      vecs[2] = '{base: 16'hFFF0, step: 16'h0001, bad: 16'h0000, gap: 0, exp_ok: 1'b1};
      vecs[3] = '{base: 16'h8000, step: 16'h0101, bad: 16'hFFFF, gap: 0, exp_ok: 1'b0};
      vecs[4] = '{base: 16'hA5C3, step: 16'h0000, bad: 16'h0000, gap: 0, exp_ok: 1'b1};

      rstn = 1'b0; in_data = 16'h0; in_valid = 1'b0; abort = 1'b0;
      clear_model();
      tick();
      tick();
      chk("reset ready_low", 32'(in_ready), 32'd0);
      chk("reset ok", 32'(frame_ok), 32'd0);
      chk("reset err", 32'(frame_err), 32'd0);
      chk_bank("reset");
      rstn = 1'b1;
      tick();
      chk("post_reset ready", 32'(in_ready), 32'd1);

      // Bad checksum before anything committed.
      send_plan_frame(16'h0304);
      chk("bad err_pulse", 32'(frame_err), 32'd1);
      chk("bad ready", 32'(in_ready), 32'd1);
      tick();
      chk("bad err_clear", 32'(frame_err), 32'd0);
      chk("bad ok", 32'(frame_ok), 32'd0);
      chk_bank("bad");

      // Good frame, valid held high across COMMIT.
      send_plan_frame(16'h0303);
      in_valid = 1'b1;
      in_data  = 16'h0000;
      chk("good ok_early", 32'(frame_ok), 32'd0);
      chk("good commit_ready", 32'(in_ready), 32'd0);
      chk("good no_err", 32'(frame_err), 32'd0);
      tick();
      chk("good ok_pulse", 32'(frame_ok), 32'd1);
      chk("good ready_back", 32'(in_ready), 32'd1);
      chk("good w00", 32'(w_out[0][0]), 32'd1);
      chk("good w01", 32'(w_out[0][1]), 32'd2);
      chk("good w02", 32'(w_out[0][2]), 32'd3);
      chk("good w52", 32'(w_out[5][2]), 32'd18);
      chk("good c0", 32'(c_out[0]), 32'd100);
      chk("good c1", 32'(c_out[1]), 32'd200);
      chk("good c2", 32'(c_out[2]), 32'd300);
      chk("good cv", 32'(coef_valid), 32'd1);
      tick();
      chk("good ok_one_cycle", 32'(frame_ok), 32'd0);
      chk("good ready_held", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      for (int k = 0; k < 18; k++) exp_w[k / 3][k % 3] = 16'(k + 1);
      exp_c[0] = 16'd100; exp_c[1] = 16'd200; exp_c[2] = 16'd300;
      exp_cv = 1'b1;

      for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

      // All-ones frame, checksum wraps to 0xFFEB.
      send_word(16'hA5C3, 0);
      for (int k = 0; k < 21; k++) send_word(16'hFFFF, 0);
      send_word(16'hFFEB, 0);
      tick();
      chk("ones ok_pulse", 32'(frame_ok), 32'd1);
      for (int d = 0; d < 6; d++)
         for (int k = 0; k < 3; k++)
            exp_w[d][k] = 16'hFFFF;
      for (int k = 0; k < 3; k++) exp_c[k] = 16'hFFFF;
      chk_bank("ones");

      // Abort after 10th weight, with a word presented on the abort edge.
      send_word(16'hA5C3, 0);
      for (int k = 0; k < 10; k++) send_word(16'h0777, 0);
      abort = 1'b1; in_valid = 1'b1; in_data = 16'h0777;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 12; k++) send_word(16'h0777, 0);
      chk("abort no_err", 32'(frame_err), 32'd0);
      tick();
      chk("abort no_ok", 32'(frame_ok), 32'd0);
      chk_bank("abort");
      run_frame("after_abort", '{base: 16'h0300, step: 16'h0011, bad: 16'h0, gap: 0, exp_ok: 1'b1});

      // Abort during COMMIT suppresses the commit.
      send_word(16'hA5C3, 0);
      for (int k = 0; k < 21; k++) send_word(16'h0002, 0);
      send_word(16'h002A, 0);
      chk("abort_commit state", 32'(in_ready), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_commit no_ok", 32'(frame_ok), 32'd0);
      chk("abort_commit ready", 32'(in_ready), 32'd1);
      tick();
      chk("abort_commit no_ok_late", 32'(frame_ok), 32'd0);
      chk_bank("abort_commit");

      // Garbage before header plus random valid gaps.
      send_word(16'h1234, 0);
      send_word(16'h0000, 0);
      run_frame("gaps", '{base: 16'h4000, step: 16'h0123, bad: 16'h0, gap: 3, exp_ok: 1'b1});

      // Reset in the middle of LOAD_C.
      send_word(16'hA5C3, 0);
      for (int k = 0; k < 19; k++) send_word(16'h0055, 0);
      rstn = 1'b0;
      tick();
      chk("midreset ready", 32'(in_ready), 32'd0);
      clear_model();
      chk_bank("midreset");
      rstn = 1'b1;
      tick();
      run_frame("post_midreset", '{base: 16'h0900, step: 16'h0002, bad: 16'h0, gap: 1,
                                   exp_ok: 1'b1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
